ecg_host_link: RTL and testbench



---
 rtl/ecg_host_link.sv | 206 ++++++++++++++++++++
 tb/tb_ecg_host_link.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ecg_host_link.sv
// Word-serial host link around an external point_scalar_mult core: load operands, run, stream result.
// Optional watchdog on the RUN state: define ECG_HOST_WATCHDOG_EN.
`ifndef WIDTH
`define WIDTH 47
`endif
`ifndef SCALAR_WIDTH
`define SCALAR_WIDTH 15
`endif

module ecg_host_link #(
  parameter int unsigned TIMEOUT_CYCLES = 32'd16777215
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_data,
  output logic                     core_reset,
  output logic [`WIDTH:0]          core_x1,
  output logic [`WIDTH:0]          core_y1,
  output logic                     core_zero1,
  output logic [`SCALAR_WIDTH:0]   core_c,
  input  logic                     core_done,
  input  logic [`WIDTH:0]          core_x3,
  input  logic [`WIDTH:0]          core_y3,
  input  logic                     core_zero3,
  output logic                     busy
);

  localparam int unsigned WX   = `WIDTH + 1;
  localparam int unsigned WC   = `SCALAR_WIDTH + 1;
  localparam int unsigned NX   = (WX + 31) / 32;
  localparam int unsigned NC   = (WC + 31) / 32;
  localparam int unsigned NIN  = 1 + 2 * NX + NC;
  localparam int unsigned NOUT = 1 + 2 * NX;
  localparam int unsigned CW   = $clog2(NIN);

  typedef enum logic [1:0] {LOAD, START, RUN, UNLOAD} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [WX-1:0]   x1_q, x1_d, y1_q, y1_d, x3_q, x3_d, y3_q, y3_d;
  logic [WC-1:0]   c_q, c_d;
  logic            zero1_q, zero1_d, zero3_q, zero3_d, tout_q, tout_d;
  logic            in_ready_q, in_ready_d, out_valid_q, out_valid_d;
  logic            core_reset_q, core_reset_d, busy_q, busy_d;
  logic [31:0]     out_data_q, out_data_d;
  logic            in_fire, out_fire, timeout_c;

`ifdef ECG_HOST_WATCHDOG_EN
  logic [31:0] wd_q, wd_d;

  // Cycle counter that only runs while waiting for the core
  always_comb begin
    wd_d      = '0;
    timeout_c = 1'b0;
    if (state_q == RUN) begin
      if (wd_q == 32'(TIMEOUT_CYCLES) - 32'd1) timeout_c = 1'b1;
      else                                      wd_d      = wd_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) wd_q <= '0;
    else        wd_q <= wd_d;
  end
`else
  logic unused_timeout;

  always_comb begin
    timeout_c      = 1'b0;
    unused_timeout = (TIMEOUT_CYCLES == 32'd0);
  end
`endif

  // Next-state, operand/result capture and registered output decode
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    x1_d       = x1_q;
    y1_d       = y1_q;
    c_d        = c_q;
    zero1_d    = zero1_q;
    x3_d       = x3_q;
    y3_d       = y3_q;
    zero3_d    = zero3_q;
    tout_d     = tout_q;
    out_data_d = '0;
    in_fire    = in_ready_q & in_valid;
    out_fire   = out_valid_q & out_ready;

    case (state_q)
      LOAD: begin
        if (in_fire) begin
          if (cnt_q == '0) zero1_d = in_data[0];
          for (int b = 0; b < WX; b++) begin
            if (cnt_q == CW'(1 + b / 32))      x1_d[b] = in_data[b % 32];
            if (cnt_q == CW'(1 + NX + b / 32)) y1_d[b] = in_data[b % 32];
          end
          for (int b = 0; b < WC; b++) begin
            if (cnt_q == CW'(1 + 2 * NX + b / 32)) c_d[b] = in_data[b % 32];
          end
          if (cnt_q == CW'(NIN - 1)) begin
            state_d = START;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      START: state_d = RUN;
      RUN: begin
        if (core_done) begin
          x3_d    = core_x3;
          y3_d    = core_y3;
          zero3_d = core_zero3;
          tout_d  = 1'b0;
          state_d = UNLOAD;
          cnt_d   = '0;
        end else if (timeout_c) begin
          x3_d    = '0;
          y3_d    = '0;
          zero3_d = 1'b0;
          tout_d  = 1'b1;
          state_d = UNLOAD;
          cnt_d   = '0;
        end
      end
      UNLOAD: begin
        if (out_fire) begin
          if (cnt_q == CW'(NOUT - 1)) begin
            state_d = LOAD;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: state_d = LOAD;
    endcase

    // Word selection follows the next counter so out_data stays put during a stall
    if (state_d == UNLOAD) begin
      if (cnt_d == '0) out_data_d[1:0] = {tout_d, zero3_d};
      for (int b = 0; b < WX; b++) begin
        if (cnt_d == CW'(1 + b / 32))      out_data_d[b % 32] = x3_d[b];
        if (cnt_d == CW'(1 + NX + b / 32)) out_data_d[b % 32] = y3_d[b];
      end
    end

    in_ready_d   = (state_d == LOAD);
    out_valid_d  = (state_d == UNLOAD);
    core_reset_d = (state_d != RUN);
    busy_d       = (state_d != LOAD);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= LOAD;
      cnt_q        <= '0;
      x1_q         <= '0;
      y1_q         <= '0;
      c_q          <= '0;
      zero1_q      <= 1'b0;
      x3_q         <= '0;
      y3_q         <= '0;
      zero3_q      <= 1'b0;
      tout_q       <= 1'b0;
      out_data_q   <= '0;
      in_ready_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      core_reset_q <= 1'b1;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      x1_q         <= x1_d;
      y1_q         <= y1_d;
      c_q          <= c_d;
      zero1_q      <= zero1_d;
      x3_q         <= x3_d;
      y3_q         <= y3_d;
      zero3_q      <= zero3_d;
      tout_q       <= tout_d;
      out_data_q   <= out_data_d;
      in_ready_q   <= in_ready_d;
      out_valid_q  <= out_valid_d;
      core_reset_q <= core_reset_d;
      busy_q       <= busy_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign core_reset = core_reset_q;
  assign busy       = busy_q;
  assign core_x1    = x1_q;
  assign core_y1    = y1_q;
  assign core_zero1 = zero1_q;
  assign core_c     = c_q;

endmodule

// File: tb/tb_ecg_host_link.sv
// Bench for ecg_host_link: toy multiplier model, vector table and scoreboard on the result stream.
`ifndef WIDTH
`define WIDTH 47
`endif
`ifndef SCALAR_WIDTH
`define SCALAR_WIDTH 15
`endif

module tb_ecg_host_link;

  localparam int unsigned WX   = `WIDTH + 1;
  localparam int unsigned WC   = `SCALAR_WIDTH + 1;
  localparam int unsigned NX   = (WX + 31) / 32;
  localparam int unsigned NC   = (WC + 31) / 32;
  localparam int unsigned NIN  = 1 + 2 * NX + NC;
  localparam int unsigned NOUT = 1 + 2 * NX;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [31:0]   in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [31:0]   out_data;
  logic          core_reset;
  logic [WX-1:0] core_x1, core_y1;
  logic          core_zero1;
  logic [WC-1:0] core_c;
  logic          core_done = 1'b0;
  logic [WX-1:0] core_x3 = '0, core_y3 = '0;
  logic          core_zero3 = 1'b0;
  logic          busy;

  ecg_host_link #(.TIMEOUT_CYCLES(32'd100)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .core_reset(core_reset), .core_x1(core_x1), .core_y1(core_y1),
    .core_zero1(core_zero1), .core_c(core_c), .core_done(core_done),
    .core_x3(core_x3), .core_y3(core_y3), .core_zero3(core_zero3),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Toy multiplier: (x*c, y*c) truncated; infinity in or c==0 gives infinity out
  function automatic logic [WX-1:0] mult(input logic [WX-1:0] a, input logic [WC-1:0] c);
    logic [WX+WC-1:0] p;
    p = a * c;
    return p[WX-1:0];
  endfunction

  int   lat = 4;
  logic hang = 1'b0;
  int   mcnt = 0;

  always @(posedge clk) begin
    if (core_reset) begin
      mcnt      <= 0;
      core_done <= 1'b0;
    end else if (!hang && !core_done) begin
      mcnt <= mcnt + 1;
      if (mcnt == lat - 1) begin
        core_done <= 1'b1;
        if (core_zero1 || core_c == '0) begin
          core_zero3 <= 1'b1;
          core_x3    <= '0;
          core_y3    <= '0;
        end else begin
          core_zero3 <= 1'b0;
          core_x3    <= mult(core_x1, core_c);
          core_y3    <= mult(core_y1, core_c);
        end
      end
    end
  end

  // Scoreboard, hold-stability and START observation
  logic [31:0] sb[$];
  logic [31:0] held = '0;
  logic        stall = 1'b0;
  int          out_words = 0;
  int          st_cnt = 0;
  logic [WX-1:0] st_x1, st_y1;
  logic [WC-1:0] st_c;
  logic        st_zero1;

  always @(negedge clk) begin
    if (!reset) begin
      stall = 1'b0;
    end else begin
      if (stall && out_valid) check("hold_stable", 64'(out_data), 64'(held));
      if (busy && core_reset && !out_valid) begin
        st_cnt++;
        st_x1 = core_x1; st_y1 = core_y1; st_c = core_c; st_zero1 = core_zero1;
      end
      if (out_valid && out_ready) begin
        out_words++;
        if (sb.size() == 0) check("unexpected_word", 64'(out_data), 64'hDEAD);
        else                check("out_word", 64'(out_data), 64'(sb.pop_front()));
      end
      stall = out_valid && !out_ready;
      held  = out_data;
    end
  end

  int bp = 0;
  initial forever begin
    @(posedge clk); #1;
    out_ready = (bp != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  typedef struct {
    logic          zero1;
    logic [WX-1:0] x1, y1;
    logic [WC-1:0] c;
    logic          exp_zero3;
    logic [WX-1:0] exp_x3, exp_y3;
    int            bp;
  } vec_t;

  vec_t        vecs[6];
  logic [31:0] fw[NIN];
  int          tput;

  task automatic build_frame(input vec_t v, input logic [31:0] junk);
    logic [NX*32-1:0] xp, yp;
    logic [NC*32-1:0] cp;
    xp = {NX{junk}}; yp = {NX{junk}}; cp = {NC{junk}};
    for (int b = 0; b < WX; b++) begin xp[b] = v.x1[b]; yp[b] = v.y1[b]; end
    for (int b = 0; b < WC; b++) cp[b] = v.c[b];
    fw[0] = {junk[31:1], v.zero1};
    for (int k = 0; k < NX; k++) begin
      fw[1 + k]      = 32'(xp >> (32 * k));
      fw[1 + NX + k] = 32'(yp >> (32 * k));
    end
    for (int k = 0; k < NC; k++) fw[1 + 2 * NX + k] = 32'(cp >> (32 * k));
  endtask

  task automatic send_words(input int nwords);
    int n;
    tput = 0;
    in_valid = 1'b1;
    for (int i = 0; i < nwords; i++) begin
      in_data = fw[i];
      n = 0;
      do begin @(negedge clk); n++; end while (!in_ready && n < 50);
      if (n >= 50) check("in_ready_timeout", 64'(n), 64'd0);
      @(posedge clk); #1;
      tput += n;
    end
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic push_expected(input logic zero3, input logic tout,
                               input logic [WX-1:0] x3, input logic [WX-1:0] y3);
    logic [NX*32-1:0] xp, yp;
    xp = (NX*32)'(x3);
    yp = (NX*32)'(y3);
    sb.push_back({30'b0, tout, zero3});
    for (int k = 0; k < NX; k++) sb.push_back(32'(xp >> (32 * k)));
    for (int k = 0; k < NX; k++) sb.push_back(32'(yp >> (32 * k)));
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (!out_valid && n < 300) begin @(posedge clk); #1; n++; end
  endtask

  task automatic drain(output int n);
    n = 0;
    while ((out_valid || sb.size() != 0) && n < 2000) begin @(posedge clk); #1; n++; end
    check("drain_done", 64'(n < 2000), 64'd1);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int n;
    bp = v.bp;
    out_words = 0;
    st_cnt = 0;
    build_frame(v, $urandom);
    send_words(NIN);
    push_expected(v.exp_zero3, 1'b0, v.exp_x3, v.exp_y3);
    check({tag, "_in_tput"}, 64'(tput), 64'(NIN));
    wait_out(n);
    check({tag, "_latency"}, 64'(n), 64'(2 + lat));
    check({tag, "_start_cycles"}, 64'(st_cnt), 64'd1);
    check({tag, "_start_x1"}, 64'(st_x1), 64'(v.x1));
    check({tag, "_start_y1"}, 64'(st_y1), 64'(v.y1));
    check({tag, "_start_c"}, 64'(st_c), 64'(v.c));
    check({tag, "_start_zero1"}, 64'(st_zero1), 64'(v.zero1));
    drain(n);
    if (v.bp == 0) check({tag, "_out_tput"}, 64'(n), 64'(NOUT));
    check({tag, "_word_count"}, 64'(out_words), 64'(NOUT));
  endtask

  task automatic reset_pulse();
    reset = 1'b0;
    @(posedge clk); #1;
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_core_reset", 64'(core_reset), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    check("post_rst_in_ready", 64'(in_ready), 64'd1);
    check("post_rst_x1", 64'(core_x1), 64'd0);
    check("post_rst_c", 64'(core_c), 64'd0);
  endtask

  task automatic watch_quiet(input string tag);
    logic seen;
    seen = 1'b0;
    repeat (40) begin @(posedge clk); #1; seen |= out_valid; end
    check(tag, 64'(seen), 64'd0);
  endtask

  initial begin
    vecs[0] = '{1'b1, '0, '0, 16'd5, 1'b1, '0, '0, 0};
    vecs[1] = '{1'b0, 48'h1234_5678_9ABC, 48'h0FED_CBA9_8765, 16'd1, 1'b0,
                48'h1234_5678_9ABC, 48'h0FED_CBA9_8765, 1};
    vecs[2] = '{1'b0, 48'hFFFF_FFFF_FFFF, 48'h8000_0000_0001, 16'd3, 1'b0,
                48'hFFFF_FFFF_FFFD, 48'h8000_0000_0003, 0};
    vecs[3] = '{1'b0, 48'hAAAA_5555_AAAA, 48'h0000_0000_0001, 16'd0, 1'b1, '0, '0, 0};
    vecs[4] = '{1'b0, 48'h0000_0001_0000, 48'h0000_0000_0002, 16'hFFFF, 1'b0,
                48'h0000_FFFF_0000, 48'h0000_0001_FFFE, 0};
    vecs[5] = '{1'b0, 48'h0000_0000_0007, 48'h0000_0000_0009, 16'h0100, 1'b0,
                48'h0000_0000_0700, 48'h0000_0000_0900, 1};

    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("init_in_ready", 64'(in_ready), 64'd0);
    check("init_out_valid", 64'(out_valid), 64'd0);
    check("init_core_reset", 64'(core_reset), 64'd1);
    check("init_busy", 64'(busy), 64'd0);
    check("init_x1", 64'(core_x1), 64'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    check("init_ready_rise", 64'(in_ready), 64'd1);

    for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Reset after 5 words of a frame: nothing emitted, next frame still correct
    bp = 0;
    build_frame(vecs[1], 32'hFFFF_FFFF);
    send_words(5);
    reset_pulse();
    check("midframe_y1_cleared", 64'(core_y1), 64'd0);
    watch_quiet("midframe_no_output");
    run_vec(vecs[2], "after_midframe");

    // Reset while the core is running: result discarded
    lat = 20;
    build_frame(vecs[4], 32'h0);
    send_words(NIN);
    repeat (5) @(posedge clk);
    #1;
    reset_pulse();
    watch_quiet("midrun_no_output");
    lat = 4;
    run_vec(vecs[4], "after_midrun");

    // in_valid pulsed during RUN/UNLOAD must be ignored
    begin
      int n;
      logic bad;
      lat = 12;
      bp = 1;
      out_words = 0;
      bad = 1'b0;
      build_frame(vecs[5], 32'h0);
      send_words(NIN);
      push_expected(vecs[5].exp_zero3, 1'b0, vecs[5].exp_x3, vecs[5].exp_y3);
      n = 0;
      while (busy && n < 500) begin
        bad |= in_ready;
        in_valid = ~in_valid;
        in_data  = $urandom;
        @(posedge clk); #1;
        n++;
      end
      in_valid = 1'b0;
      check("pulse_in_ready_low", 64'(bad), 64'd0);
      check("pulse_x1_kept", 64'(core_x1), 64'(vecs[5].x1));
      check("pulse_y1_kept", 64'(core_y1), 64'(vecs[5].y1));
      check("pulse_c_kept", 64'(core_c), 64'(vecs[5].c));
      check("pulse_words", 64'(out_words), 64'(NOUT));
      check("pulse_sb_empty", 64'(sb.size()), 64'd0);
      lat = 4;
      bp = 0;
    end

`ifdef ECG_HOST_WATCHDOG_EN
    begin
      int n;
      hang = 1'b1;
      out_words = 0;
      build_frame(vecs[2], 32'h0);
      send_words(NIN);
      push_expected(1'b0, 1'b1, '0, '0);
      wait_out(n);
      check("wd_latency_window", 64'(n >= 99 && n <= 103), 64'd1);
      drain(n);
      check("wd_words", 64'(out_words), 64'(NOUT));
      hang = 1'b0;
    end
`endif

    check("final_sb_empty", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
